// File: rtl/appx_mult_pkg.sv
// Shared constants, the operand-stage record and a reference approximate multiply.
package appx_mult_pkg;

    localparam int unsigned W_DEFAULT = 16;
    localparam int unsigned CNT_W     = 16;
    // Record id field is wide enough for the largest supported requester count (8).
    localparam int unsigned ID_W_MAX  = 3;

    typedef struct packed {
        logic [W_DEFAULT-1:0] a;
        logic [W_DEFAULT-1:0] b;
        logic [ID_W_MAX-1:0]  id;
        logic                 exact;
    } s1_rec_t;

    // Leading-one approximation: a*b ~ a * (top one or top two set bits of b).
    function automatic logic [2*W_DEFAULT-1:0] appx_mult(input logic [W_DEFAULT-1:0] a,
                                                         input logic [W_DEFAULT-1:0] b);
        logic [$clog2(W_DEFAULT)-1:0] k;
        logic                         nz;
        logic [W_DEFAULT+1:0]         a3;
        k  = '0;
        nz = 1'b0;
        for (int i = 0; i < W_DEFAULT; i++) begin
            if (b[i]) begin
                k  = i[$clog2(W_DEFAULT)-1:0];
                nz = 1'b1;
            end
        end
        a3 = {2'b00, a} + {1'b0, a, 1'b0};
        if (!nz) begin
            return '0;
        end
        if ((k != '0) && b[k - 1'b1]) begin
            return (2*W_DEFAULT)'(a3) << (k - 1'b1);
        end
        return (2*W_DEFAULT)'(a) << k;
    endfunction

endpackage

// File: rtl/appx_mult_sched_if.sv
// Request/response bundle between the requesters and the shared multiplier.
interface appx_mult_sched_if import appx_mult_pkg::*; #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned W    = W_DEFAULT
);
    localparam int unsigned IDW = $clog2(NREQ);

    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [NREQ-1:0]   req_exact;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [2*W-1:0]    rsp_y;
    logic [IDW-1:0]    rsp_id;
    logic              rsp_exact;

    modport master (
        output req_valid, req_a, req_b, req_exact, rsp_ready,
        input  req_ready, rsp_valid, rsp_y, rsp_id, rsp_exact
    );

    modport slave (
        input  req_valid, req_a, req_b, req_exact, rsp_ready,
        output req_ready, rsp_valid, rsp_y, rsp_id, rsp_exact
    );
endinterface

// File: rtl/appx_mult_core.sv
// Combinational exact / approximate unsigned multiplier.
module appx_mult_core import appx_mult_pkg::*; #(
    parameter int unsigned W = W_DEFAULT
) (
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    input  logic           exact,
    output logic [2*W-1:0] y
);
    localparam int unsigned KW = $clog2(W);

    logic [KW-1:0] k;
    logic          nz;
    logic          second;
    logic [W+1:0]  a3;

    // Locate the most significant set bit of b.
    always_comb begin
        k  = '0;
        nz = 1'b0;
        for (int i = 0; i < W; i++) begin
            if (b[i]) begin
                k  = KW'(i);
                nz = 1'b1;
            end
        end
    end

    assign a3     = {2'b00, a} + {1'b0, a, 1'b0};
    assign second = (k != '0) && b[k - 1'b1];

    // Select exact product or the shifted a / 3a approximation.
    always_comb begin
        if (exact) begin
            y = (2*W)'(a) * (2*W)'(b);
        end else if (!nz) begin
            y = '0;
        end else if (second) begin
            y = (2*W)'(a3) << (k - 1'b1);
        end else begin
            y = (2*W)'(a) << k;
        end
    end
endmodule

// File: rtl/appx_mult_sched.sv
// Round-robin scheduler feeding one two-stage multiply pipeline, with an approx-op counter.
module appx_mult_sched import appx_mult_pkg::*; #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned W    = W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    appx_mult_sched_if.slave  bus,
    input  logic              cnt_clr,
    output logic              busy,
    output logic [CNT_W-1:0]  appx_count
);
    localparam int unsigned IDW = $clog2(NREQ);

    s1_rec_t          s1_q, s1_d;
    logic             s1_valid_q;
    logic [2*W-1:0]   s2_y_q;
    logic [IDW-1:0]   s2_id_q, s2_id_d;
    logic             s2_exact_q, s2_valid_q;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             s2_en, s1_acc, hs, found, rsp_hs;
    logic [NREQ-1:0]  grant;
    logic [IDW-1:0]   gnt_id;
    logic [IDW:0]     cand_w;
    logic [W-1:0]     sel_a, sel_b;
    logic             sel_exact;
    logic [2*W-1:0]   core_y;

    assign s2_en  = !s2_valid_q || bus.rsp_ready;
    assign s1_acc = !s1_valid_q || s2_en;
    assign rsp_hs = s2_valid_q && bus.rsp_ready;

    // First valid requester at or above the pointer, wrapping modulo NREQ.
    always_comb begin
        grant  = '0;
        gnt_id = '0;
        found  = 1'b0;
        cand_w = '0;
        for (int off = 0; off < NREQ; off++) begin
            cand_w = {1'b0, ptr_q} + (IDW+1)'(off);
            if (cand_w >= (IDW+1)'(NREQ)) begin
                cand_w = cand_w - (IDW+1)'(NREQ);
            end
            if (!found && bus.req_valid[cand_w[IDW-1:0]]) begin
                grant[cand_w[IDW-1:0]] = 1'b1;
                gnt_id                 = cand_w[IDW-1:0];
                found                  = 1'b1;
            end
        end
    end

    // Grants are suppressed during reset so all outputs read zero.
    assign bus.req_ready = grant & {NREQ{s1_acc & ~rst}};
    assign hs            = found & s1_acc & ~rst;

    // Operand mux for the granted requester.
    always_comb begin
        sel_a     = '0;
        sel_b     = '0;
        sel_exact = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_id == IDW'(i)) begin
                sel_a     = bus.req_a[i*W +: W];
                sel_b     = bus.req_b[i*W +: W];
                sel_exact = bus.req_exact[i];
            end
        end
        s1_d = '{a: W_DEFAULT'(sel_a), b: W_DEFAULT'(sel_b),
                 id: ID_W_MAX'(gnt_id), exact: sel_exact};
    end

    // Narrow the record id back to the local id width.
    always_comb begin
        s2_id_d = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (s1_q.id == ID_W_MAX'(i)) begin
                s2_id_d = IDW'(i);
            end
        end
    end

    appx_mult_core #(.W(W)) u_core (
        .a     (W'(s1_q.a)),
        .b     (W'(s1_q.b)),
        .exact (s1_q.exact),
        .y     (core_y)
    );

    // Pointer moves past the winner only on an actual handshake.
    always_comb begin
        ptr_d = ptr_q;
        if (hs) begin
            ptr_d = (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;
        end
    end

    // Saturating approx-op counter; clear wins over increment.
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (rsp_hs && !s2_exact_q && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Operand stage: load on grant, hold while blocked.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_q       <= '0;
        end else if (s1_acc) begin
            s1_valid_q <= hs;
            if (hs) begin
                s1_q <= s1_d;
            end
        end
    end

    // Result stage: reload whenever empty or being consumed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid_q <= 1'b0;
            s2_y_q     <= '0;
            s2_id_q    <= '0;
            s2_exact_q <= 1'b0;
        end else if (s2_en) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_y_q     <= core_y;
                s2_id_q    <= s2_id_d;
                s2_exact_q <= s1_q.exact;
            end
        end
    end

    // Arbiter pointer and counter state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
            cnt_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
        end
    end

    assign bus.rsp_valid = s2_valid_q;
    assign bus.rsp_y     = s2_y_q;
    assign bus.rsp_id    = s2_id_q;
    assign bus.rsp_exact = s2_exact_q;
    assign busy          = s1_valid_q | s2_valid_q;
    assign appx_count    = cnt_q;
endmodule

// File: tb/tb_appx_mult_sched.sv
// Directed self-checking bench for appx_mult_sched.
module tb_appx_mult_sched;
    import appx_mult_pkg::*;

    localparam int unsigned NREQ = 4;
    localparam int unsigned W    = 16;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        ex;
        logic [31:0] y;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             cnt_clr;
    logic             busy;
    logic [CNT_W-1:0] appx_count;

    int n_checks = 0;
    int n_errors = 0;
    int appx_seen = 0;
    logic [33:0] rsp_log[$];

    appx_mult_sched_if #(.NREQ(NREQ), .W(W)) bus ();

    appx_mult_sched #(.NREQ(NREQ), .W(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus.slave),
        .cnt_clr    (cnt_clr),
        .busy       (busy),
        .appx_count (appx_count)
    );

    always #5 clk = ~clk;

    // Record response handshakes that will happen at the coming rising edge.
    always @(negedge clk) begin
        if (!rst && bus.rsp_valid && bus.rsp_ready) begin
            rsp_log.push_back({bus.rsp_id, bus.rsp_y});
            if (!bus.rsp_exact) appx_seen++;
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_one(input int id, input logic [15:0] a, input logic [15:0] b,
                             input logic ex, input logic [31:0] exp_y, input string tag);
        int n;
        bus.req_a[id*W +: W] = a;
        bus.req_b[id*W +: W] = b;
        bus.req_exact[id]    = ex;
        bus.req_valid        = '0;
        bus.req_valid[id]    = 1'b1;
        #1;
        n = 0;
        while (bus.req_ready[id] !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        check_eq({tag, "_grant"}, 64'(bus.req_ready), 64'(1) << id);
        tick();
        bus.req_valid = '0;
        check_eq({tag, "_lat1"}, 64'(bus.rsp_valid), 64'(0));
        tick();
        check_eq({tag, "_valid"}, 64'(bus.rsp_valid), 64'(1));
        check_eq({tag, "_y"}, 64'(bus.rsp_y), 64'(exp_y));
        check_eq({tag, "_id"}, 64'(bus.rsp_id), 64'(id));
        check_eq({tag, "_exact"}, 64'(bus.rsp_exact), 64'(ex));
        tick();
        check_eq({tag, "_drained"}, 64'(busy), 64'(0));
    endtask

    vec_t corners[9] = '{
        '{16'd65535, 16'd65535,  1'b0, 32'hBFFF_4000},  // (3*65535) << 14
        '{16'd65535, 16'd65535,  1'b1, 32'hFFFE_0001},
        '{16'd1234,  16'd0,      1'b0, 32'd0},
        '{16'd1234,  16'd1,      1'b0, 32'd1234},
        '{16'd1000,  16'd3,      1'b0, 32'd3000},
        '{16'd1000,  16'd5,      1'b0, 32'd4000},
        '{16'd7,     16'd9,      1'b0, 32'd56},
        '{16'd3,     16'h8000,   1'b0, 32'd98304},
        '{16'd40000, 16'd0,      1'b1, 32'd0}
    };
    int rr_order[6] = '{0, 1, 2, 3, 0, 1};
    int bp_id[3]    = '{2, 0, 1};
    int bp_y[3]     = '{90, 30, 60};

    initial begin
        logic [NREQ-1:0] g;
        int n;

        // Reset with requests pending: everything reads zero.
        rst           = 1'b1;
        cnt_clr       = 1'b0;
        bus.req_valid = '1;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_exact = '0;
        bus.rsp_ready = 1'b1;
        repeat (2) tick();
        check_eq("rst_req_ready", 64'(bus.req_ready), 64'(0));
        check_eq("rst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
        check_eq("rst_rsp_y", 64'(bus.rsp_y), 64'(0));
        check_eq("rst_busy", 64'(busy), 64'(0));
        check_eq("rst_count", 64'(appx_count), 64'(0));
        bus.req_valid = '0;
        rst           = 1'b0;
        tick();

        issue_one(2, 16'd100, 16'd7, 1'b0, 32'd600, "single_appx");
        issue_one(2, 16'd100, 16'd7, 1'b1, 32'd700, "single_exact");
        check_eq("count_single", 64'(appx_count), 64'(1));

        for (int i = 0; i < 9; i++) begin
            issue_one(3, corners[i].a, corners[i].b, corners[i].ex, corners[i].y,
                      $sformatf("corner%0d", i));
        end
        check_eq("count_corners", 64'(appx_count), 64'(8));

        // All requesters valid, no backpressure: strict rotation at one op per cycle.
        for (int i = 0; i < NREQ; i++) begin
            bus.req_a[i*W +: W] = 16'(i + 1);
            bus.req_b[i*W +: W] = 16'd2;
        end
        bus.req_exact = '1;
        bus.req_valid = '1;
        for (int k = 0; k < 8; k++) begin
            if (k == 6) bus.req_valid = '0;
            #1;
            if (k < 6) check_eq($sformatf("rr_grant%0d", k), 64'(bus.req_ready),
                                64'(1) << rr_order[k]);
            else check_eq("rr_idle", 64'(bus.req_ready), 64'(0));
            if (k >= 2) begin
                check_eq("rr_rsp_valid", 64'(bus.rsp_valid), 64'(1));
                check_eq("rr_rsp_id", 64'(bus.rsp_id), 64'(rr_order[k-2]));
                check_eq("rr_rsp_y", 64'(bus.rsp_y), 64'(2 * (rr_order[k-2] + 1)));
            end
            tick();
        end

        // Backpressure: three requesters, response side stalled for four cycles.
        for (int i = 0; i < NREQ; i++) begin
            bus.req_a[i*W +: W] = 16'(10 * (i + 1));
            bus.req_b[i*W +: W] = 16'd3;
        end
        bus.req_exact = '0;
        bus.rsp_ready = 1'b0;
        rsp_log.delete();
        bus.req_valid = 4'b0111;
        g = '0;
        for (int k = 0; k < 10; k++) begin
            bus.req_valid = bus.req_valid & ~g;
            bus.rsp_ready = (k >= 6);
            #1;
            g = bus.req_ready;
            if (k >= 2 && k < 6) begin
                check_eq("bp_no_grant", 64'(bus.req_ready), 64'(0));
                check_eq("bp_valid", 64'(bus.rsp_valid), 64'(1));
                check_eq("bp_hold_y", 64'(bus.rsp_y), 64'(90));
                check_eq("bp_hold_id", 64'(bus.rsp_id), 64'(2));
            end
            tick();
        end
        check_eq("bp_count", 64'(rsp_log.size()), 64'(3));
        for (int k = 0; k < 3; k++) begin
            if (k < rsp_log.size()) begin
                check_eq($sformatf("bp_order_id%0d", k), 64'(rsp_log[k][33:32]), 64'(bp_id[k]));
                check_eq($sformatf("bp_order_y%0d", k), 64'(rsp_log[k][31:0]), 64'(bp_y[k]));
            end
        end
        check_eq("count_bp", 64'(appx_count), 64'(11));

        // Counter: clear, then stream approximate ops past saturation.
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        appx_seen = 0;
        check_eq("cnt_clr_idle", 64'(appx_count), 64'(0));
        bus.req_a[0 +: W] = 16'd5;
        bus.req_b[0 +: W] = 16'd5;
        bus.req_exact     = '0;
        bus.rsp_ready     = 1'b1;
        bus.req_valid     = 4'b0001;
        n = 0;
        while (appx_seen < 65537 && n < 70000) begin
            tick();
            n++;
            if (appx_seen == 10) check_eq("cnt_10", 64'(appx_count), 64'(10));
            if (appx_seen == 65534) check_eq("cnt_65534", 64'(appx_count), 64'(65534));
        end
        check_eq("cnt_budget", 64'(n < 70000), 64'(1));
        check_eq("cnt_sat", 64'(appx_count), 64'(16'hFFFF));
        // Clear in the same cycle as a response handshake.
        check_eq("clr_hs_valid", 64'(bus.rsp_valid), 64'(1));
        cnt_clr = 1'b1;
        tick();
        cnt_clr   = 1'b0;
        appx_seen = 0;
        check_eq("clr_with_hs", 64'(appx_count), 64'(0));
        tick();
        check_eq("cnt_after_clr", 64'(appx_count), 64'(1));
        bus.req_valid = '0;
        repeat (3) tick();

        // Reset with both stages full; pointer was left at 3 before the reset.
        for (int i = 0; i < NREQ; i++) begin
            bus.req_a[i*W +: W] = 16'(11 * (i + 1));
            bus.req_b[i*W +: W] = 16'd1;
        end
        bus.req_exact = '1;
        bus.rsp_ready = 1'b0;
        bus.req_valid = 4'b0110;
        tick();
        tick();
        check_eq("pre_rst_busy", 64'(busy), 64'(1));
        check_eq("pre_rst_valid", 64'(bus.rsp_valid), 64'(1));
        rst = 1'b1;
        #1;
        check_eq("async_rst_valid", 64'(bus.rsp_valid), 64'(0));
        check_eq("async_rst_y", 64'(bus.rsp_y), 64'(0));
        check_eq("async_rst_busy", 64'(busy), 64'(0));
        check_eq("async_rst_ready", 64'(bus.req_ready), 64'(0));
        rsp_log.delete();
        tick();
        rst           = 1'b0;
        bus.req_valid = 4'b1010;
        bus.rsp_ready = 1'b1;
        #1;
        check_eq("post_rst_grant", 64'(bus.req_ready), 64'(4'b0010));
        tick();
        bus.req_valid = '0;
        repeat (4) tick();
        check_eq("post_rst_rsp_cnt", 64'(rsp_log.size()), 64'(1));
        if (rsp_log.size() > 0) begin
            check_eq("post_rst_rsp_id", 64'(rsp_log[0][33:32]), 64'(1));
            check_eq("post_rst_rsp_y", 64'(rsp_log[0][31:0]), 64'(22));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
